theremin_oversampling_iserdes_period_measure: RTL and testbench

THEREMIN_OVERSAMPLING_ISERDES_PERIOD_MEASURE -- requirements
Module: theremin_oversampling_iserdes_period_measure

---
 rtl/theremin_oversampling_iserdes_period_measure.sv | 151 +++++++++++++++
 tb/tb_theremin_oversampling_iserdes_period_measure.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/theremin_oversampling_iserdes_period_measure.sv
// Theremin period meter: measures pitch and volume half-periods from oversampled
// deserialized input words and smooths each with a first-order IIR filter.

module theremin_period_channel #(
    parameter int PERIOD_BITS       = 16,
    parameter int DATA_BITS         = 28,
    parameter int FILTER_SHIFT_BITS = 8,
    parameter int OVERSAMPLE        = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [OVERSAMPLE-1:0]  SAMPLES,
    output logic [PERIOD_BITS-1:0] PERIOD_NOFILTER,
    output logic [DATA_BITS-1:0]   PERIOD_FILTERED
);

    localparam int IDX_BITS  = $clog2(OVERSAMPLE + 1);
    localparam int ACC_SHIFT = DATA_BITS - PERIOD_BITS - FILTER_SHIFT_BITS;
    localparam logic [PERIOD_BITS-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_BITS:0]   OS_WIDE    = (PERIOD_BITS + 1)'(OVERSAMPLE);

    logic                   prev_sample;
    logic                   first_edge;
    logic                   walk_bit;
    logic [1:0]             edge_count;
    logic [IDX_BITS-1:0]    last_idx;
    logic [IDX_BITS-1:0]    prior_idx;
    logic [PERIOD_BITS-1:0] cnt;
    logic [PERIOD_BITS-1:0] cnt_next;
    logic [PERIOD_BITS-1:0] measured;
    logic [PERIOD_BITS:0]   first_sum;
    logic [PERIOD_BITS:0]   idle_sum;
    logic                   meas_valid;
    logic                   meas_valid_q;
    logic [DATA_BITS-1:0]   acc;
    logic [DATA_BITS-1:0]   acc_next;

    // Walk the word oldest-first; only the last two transitions matter, and
    // edge_count saturates at 2 since we only need to know "one" vs "several".
    always_comb begin
        walk_bit   = prev_sample;
        edge_count = 2'd0;
        last_idx   = '0;
        prior_idx  = '0;
        for (int i = 0; i < OVERSAMPLE; i++) begin
            if (SAMPLES[OVERSAMPLE-1-i] != walk_bit) begin
                prior_idx = last_idx;
                last_idx  = IDX_BITS'(i);
                if (edge_count != 2'd2) begin
                    edge_count = edge_count + 2'd1;
                end
            end
            walk_bit = SAMPLES[OVERSAMPLE-1-i];
        end
    end

    assign first_sum = {1'b0, cnt} + (PERIOD_BITS + 1)'(last_idx);
    assign idle_sum  = {1'b0, cnt} + OS_WIDE;

    // A lone transition closes the span carried over from earlier words;
    // with several, the reported span lies wholly inside this word.
    always_comb begin
        if (edge_count == 2'd1) begin
            measured = first_sum[PERIOD_BITS] ? PERIOD_MAX : first_sum[PERIOD_BITS-1:0];
        end else begin
            measured = PERIOD_BITS'(last_idx - prior_idx);
        end
        meas_valid = (edge_count != 2'd0) && !(first_edge && edge_count == 2'd1);
        if (edge_count == 2'd0) begin
            cnt_next = idle_sum[PERIOD_BITS] ? PERIOD_MAX : idle_sum[PERIOD_BITS-1:0];
        end else begin
            cnt_next = PERIOD_BITS'(OVERSAMPLE) - PERIOD_BITS'(last_idx);
        end
    end

    assign acc_next = acc - (acc >> FILTER_SHIFT_BITS)
                    + (DATA_BITS'(PERIOD_NOFILTER) << ACC_SHIFT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_sample     <= 1'b0;
            first_edge      <= 1'b1;
            cnt             <= '0;
            PERIOD_NOFILTER <= '0;
            meas_valid_q    <= 1'b0;
            acc             <= '0;
        end else begin
            prev_sample  <= SAMPLES[0];
            cnt          <= cnt_next;
            meas_valid_q <= meas_valid;
            if (edge_count != 2'd0) begin
                first_edge <= 1'b0;
            end
            if (meas_valid) begin
                PERIOD_NOFILTER <= measured;
            end
            // NOFILTER doubles as the pipeline register feeding the filter.
            if (meas_valid_q) begin
                acc <= acc_next;
            end
        end
    end

    assign PERIOD_FILTERED = acc;

endmodule

module theremin_oversampling_iserdes_period_measure #(
    parameter int PITCH_PERIOD_BITS  = 16,
    parameter int VOLUME_PERIOD_BITS = 16,
    parameter int DATA_BITS          = 28,
    parameter int FILTER_SHIFT_BITS  = 8,
    parameter int OVERSAMPLE         = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [OVERSAMPLE-1:0]         PITCH_SAMPLES,
    input  logic [OVERSAMPLE-1:0]         VOLUME_SAMPLES,
    output logic [PITCH_PERIOD_BITS-1:0]  PITCH_PERIOD_NOFILTER,
    output logic [VOLUME_PERIOD_BITS-1:0] VOLUME_PERIOD_NOFILTER,
    output logic [DATA_BITS-1:0]          PITCH_PERIOD_FILTERED,
    output logic [DATA_BITS-1:0]          VOLUME_PERIOD_FILTERED
);

    theremin_period_channel #(
        .PERIOD_BITS      (PITCH_PERIOD_BITS),
        .DATA_BITS        (DATA_BITS),
        .FILTER_SHIFT_BITS(FILTER_SHIFT_BITS),
        .OVERSAMPLE       (OVERSAMPLE)
    ) pitch_channel (
        .CLK            (CLK),
        .RESET          (RESET),
        .SAMPLES        (PITCH_SAMPLES),
        .PERIOD_NOFILTER(PITCH_PERIOD_NOFILTER),
        .PERIOD_FILTERED(PITCH_PERIOD_FILTERED)
    );

    theremin_period_channel #(
        .PERIOD_BITS      (VOLUME_PERIOD_BITS),
        .DATA_BITS        (DATA_BITS),
        .FILTER_SHIFT_BITS(FILTER_SHIFT_BITS),
        .OVERSAMPLE       (OVERSAMPLE)
    ) volume_channel (
        .CLK            (CLK),
        .RESET          (RESET),
        .SAMPLES        (VOLUME_SAMPLES),
        .PERIOD_NOFILTER(VOLUME_PERIOD_NOFILTER),
        .PERIOD_FILTERED(VOLUME_PERIOD_FILTERED)
    );

endmodule

// File: tb/tb_theremin_oversampling_iserdes_period_measure.sv
// Bench for the theremin period meter: absolute-time reference model checked every
// cycle, plus directed words with hand-computed expectations.

module tb_theremin_oversampling_iserdes_period_measure;

    localparam int OS  = 8;
    localparam int PB  = 16;
    localparam int DB  = 28;
    localparam int FS  = 8;
    localparam longint PMAX = 65535;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [OS-1:0] PITCH_SAMPLES = '1;
    logic [OS-1:0] VOLUME_SAMPLES = '1;
    logic [PB-1:0] PITCH_PERIOD_NOFILTER;
    logic [PB-1:0] VOLUME_PERIOD_NOFILTER;
    logic [DB-1:0] PITCH_PERIOD_FILTERED;
    logic [DB-1:0] VOLUME_PERIOD_FILTERED;

    int tests = 0;
    int fails = 0;

    theremin_oversampling_iserdes_period_measure dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .PITCH_SAMPLES         (PITCH_SAMPLES),
        .VOLUME_SAMPLES        (VOLUME_SAMPLES),
        .PITCH_PERIOD_NOFILTER (PITCH_PERIOD_NOFILTER),
        .VOLUME_PERIOD_NOFILTER(VOLUME_PERIOD_NOFILTER),
        .PITCH_PERIOD_FILTERED (PITCH_PERIOD_FILTERED),
        .VOLUME_PERIOD_FILTERED(VOLUME_PERIOD_FILTERED)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
        tests++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Model: timestamps every serial sample on one absolute tick axis; a period
    // is simply the saturated distance between consecutive transition times.
    longint mTick;
    longint mLast[2];
    bit     mRef[2];
    bit     mPrev[2];
    longint mNof[2];
    longint mAcc[2];
    bit     mPend[2];

    always @(posedge CLK) begin
        logic [OS-1:0] w;
        longint m;
        bit got;
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? PITCH_SAMPLES : VOLUME_SAMPLES;
            if (RESET) begin
                mRef[ch]  = 1'b0;
                mPrev[ch] = 1'b0;
                mNof[ch]  = 0;
                mAcc[ch]  = 0;
                mPend[ch] = 1'b0;
            end else begin
                if (mPend[ch]) begin
                    mAcc[ch] = mAcc[ch] + (mNof[ch] << (DB - PB - FS)) - (mAcc[ch] >> FS);
                end
                mPend[ch] = 1'b0;
                got = 1'b0;
                m = 0;
                for (int i = 0; i < OS; i++) begin
                    if (w[OS-1-i] != mPrev[ch]) begin
                        if (mRef[ch]) begin
                            m = mTick + i - mLast[ch];
                            if (m > PMAX) m = PMAX;
                            got = 1'b1;
                        end
                        mLast[ch] = mTick + i;
                        mRef[ch]  = 1'b1;
                    end
                    mPrev[ch] = w[OS-1-i];
                end
                if (got) begin
                    mNof[ch]  = m;
                    mPend[ch] = 1'b1;
                end
            end
        end
        if (!RESET) mTick += OS;
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            checkOutput("pitch_nofilter_model", PITCH_PERIOD_NOFILTER, mNof[0]);
            checkOutput("volume_nofilter_model", VOLUME_PERIOD_NOFILTER, mNof[1]);
            checkOutput("pitch_filtered_model", PITCH_PERIOD_FILTERED, mAcc[0]);
            checkOutput("volume_filtered_model", VOLUME_PERIOD_FILTERED, mAcc[1]);
        end
    end

    // Square-wave generator, one per channel, producing oldest-first samples.
    int gHi[2];
    int gLo[2];
    int gRem[2];
    bit gLvl[2];

    task automatic startWave(input int ch, input int hi, input int lo, input bit lvl);
        gHi[ch]  = hi;
        gLo[ch]  = lo;
        gLvl[ch] = lvl;
        gRem[ch] = lvl ? hi : lo;
    endtask

    task automatic genWord(input int ch, output logic [OS-1:0] w);
        w = '0;
        for (int i = 0; i < OS; i++) begin
            if (gRem[ch] == 0) begin
                gLvl[ch] = ~gLvl[ch];
                gRem[ch] = gLvl[ch] ? gHi[ch] : gLo[ch];
            end
            gRem[ch]--;
            w[OS-1-i] = gLvl[ch];
        end
    endtask

    task automatic applyStimulus(input logic [OS-1:0] p, input logic [OS-1:0] v);
        PITCH_SAMPLES  = p;
        VOLUME_SAMPLES = v;
        @(negedge CLK);
    endtask

    task automatic resetFor(input int cycles, input logic [OS-1:0] w);
        RESET = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus(w, w);
        RESET = 1'b0;
    endtask

    initial begin
        logic [OS-1:0] pw;
        logic [OS-1:0] vw;
        int monoErr;
        int dutyErr;
        longint prevP;
        longint prevV;

        @(negedge CLK);
        resetFor(3, 8'hFF);

        // Held high through reset: first edge sits at index 0 and is only a reference.
        applyStimulus(8'hFF, 8'hFF);
        checkOutput("reset_pitch_nofilter", PITCH_PERIOD_NOFILTER, 0);
        checkOutput("reset_volume_nofilter", VOLUME_PERIOD_NOFILTER, 0);
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'hFF, 8'hFF);
        checkOutput("reset_pitch_filtered", PITCH_PERIOD_FILTERED, 0);
        checkOutput("reset_volume_filtered", VOLUME_PERIOD_FILTERED, 0);
        applyStimulus(8'h00, 8'h00);
        checkOutput("first_meas_24", PITCH_PERIOD_NOFILTER, 24);

        // Two transitions in one word at indices 1 and 6.
        resetFor(2, 8'h00);
        applyStimulus(8'h0F, 8'h0F);
        checkOutput("ref_edge_no_meas", PITCH_PERIOD_NOFILTER, 0);
        applyStimulus(8'h00, 8'h00);
        checkOutput("cross_word_4", PITCH_PERIOD_NOFILTER, 4);
        applyStimulus(8'h7C, 8'h7C);
        checkOutput("two_edge_word_5", PITCH_PERIOD_NOFILTER, 5);
        checkOutput("filtered_after_4", PITCH_PERIOD_FILTERED, 64);
        applyStimulus(8'h00, 8'h00);
        checkOutput("filtered_after_5", PITCH_PERIOD_FILTERED, 144);
        checkOutput("nofilter_holds", PITCH_PERIOD_NOFILTER, 5);
        applyStimulus(8'h3F, 8'h3F);
        checkOutput("counts_from_idx6", PITCH_PERIOD_NOFILTER, 12);
        checkOutput("volume_counts_from_idx6", VOLUME_PERIOD_NOFILTER, 12);
        applyStimulus(8'hFF, 8'hFF);
        checkOutput("filtered_after_12", PITCH_PERIOD_FILTERED, 336);

        // Long constant input saturates the count.
        for (int i = 0; i < 8200; i++) applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h00, 8'h00);
        checkOutput("pitch_saturated", PITCH_PERIOD_NOFILTER, 65535);
        checkOutput("volume_saturated", VOLUME_PERIOD_NOFILTER, 65535);

        // Reset in the middle of a measurement discards the partial count.
        applyStimulus(8'h0F, 8'h0F);
        resetFor(2, 8'h00);
        applyStimulus(8'hFF, 8'hFF);
        checkOutput("post_reset_ref_only", PITCH_PERIOD_NOFILTER, 0);
        applyStimulus(8'h00, 8'h00);
        checkOutput("post_reset_second_edge", PITCH_PERIOD_NOFILTER, 8);
        applyStimulus(8'h00, 8'h00);
        checkOutput("post_reset_filtered", PITCH_PERIOD_FILTERED, 128);

        // Independent square waves: pitch 20 ticks, volume 37 ticks per half-period.
        resetFor(2, 8'h00);
        startWave(0, 20, 20, 1'b0);
        startWave(1, 37, 37, 1'b0);
        monoErr = 0;
        prevP = 0;
        prevV = 0;
        for (int c = 0; c < 9000; c++) begin
            genWord(0, pw);
            genWord(1, vw);
            applyStimulus(pw, vw);
            if (PITCH_PERIOD_FILTERED < prevP) monoErr++;
            if (VOLUME_PERIOD_FILTERED < prevV) monoErr++;
            prevP = PITCH_PERIOD_FILTERED;
            prevV = VOLUME_PERIOD_FILTERED;
        end
        checkOutput("filtered_monotonic", monoErr, 0);
        checkOutput("pitch_square_nofilter", PITCH_PERIOD_NOFILTER, 20);
        checkOutput("volume_square_nofilter", VOLUME_PERIOD_NOFILTER, 37);
        checkRange("pitch_square_filtered", PITCH_PERIOD_FILTERED, 81920 - 256, 81920 + 256);
        checkRange("volume_square_filtered", VOLUME_PERIOD_FILTERED, 151552 - 256, 151552 + 256);

        // Asymmetric duty on pitch: 15 high, 25 low.
        gHi[0] = 15;
        gLo[0] = 25;
        dutyErr = 0;
        for (int c = 0; c < 6000; c++) begin
            genWord(0, pw);
            genWord(1, vw);
            applyStimulus(pw, vw);
            if (c > 20 && PITCH_PERIOD_NOFILTER != 15 && PITCH_PERIOD_NOFILTER != 25) dutyErr++;
        end
        checkOutput("duty_alternates_15_25", dutyErr, 0);
        checkRange("duty_filtered", PITCH_PERIOD_FILTERED, 81920 - 1024, 81920 + 1024);
        checkRange("duty_volume_unaffected", VOLUME_PERIOD_FILTERED, 151552 - 256, 151552 + 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
